// File: rtl/bnn_conv3x3.sv
// Binary 3x3 XNOR-popcount convolution over a 28x28 image and NFILT filters, one activation per beat.
// Optional build macro BNN_CONV_POPCNT_OUT_EN adds the raw-popcount output out_popcnt_o.
//
// state  | meaning
// IDLE   | waiting for start; first beat loaded on start
// RUN    | streaming beats, counters hold the beat in the output register
// DONE   | all beats accepted; held until reset
module bnn_conv3x3 #(
   parameter int IMG    = 28,
   parameter int NFILT  = 8,
   parameter int THRESH = 5
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        start_i,
   input  logic [IMG*IMG-1:0]          pixels_flat_i,
   input  logic [NFILT*9-1:0]          weights_flat_i,
   input  logic                        out_ready_i,
   output logic                        out_valid_o,
   output logic                        out_bit_o,
   output logic [$clog2(IMG-2)-1:0]    out_row_o,
   output logic [$clog2(IMG-2)-1:0]    out_col_o,
   output logic [$clog2(NFILT)-1:0]    out_filt_o,
   output logic                        busy_o,
`ifdef BNN_CONV_POPCNT_OUT_EN
   output logic                        done_o,
   output logic [3:0]                  out_popcnt_o
`else
   output logic                        done_o
`endif
);

   localparam int RW = $clog2(IMG-2);
   localparam int FW = $clog2(NFILT);
   localparam int PW = $clog2(IMG*IMG);
   localparam int WW = $clog2(NFILT*9);
   localparam logic [RW-1:0] RC_LAST = RW'(IMG-3);
   localparam logic [FW-1:0] F_LAST  = FW'(NFILT-1);
   localparam logic [3:0]    THR     = 4'(THRESH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [RW-1:0]   row_q, row_d, col_q, col_d;
   logic [FW-1:0]   filt_q, filt_d;
   logic            valid_q, valid_d;
   logic            bit_q;
   logic            load;
   logic [3:0]      popcnt_d;
   logic [PW-1:0]   pidx;
   logic [WW-1:0]   widx;

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      filt_d  = filt_q;
      valid_d = valid_q;
      load    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d = S_RUN;
               row_d   = '0;
               col_d   = '0;
               filt_d  = '0;
               valid_d = 1'b1;
               load    = 1'b1;
            end
         end
         S_RUN: begin
            if (valid_q && out_ready_i) begin
               if (row_q == RC_LAST && col_q == RC_LAST && filt_q == F_LAST) begin
                  valid_d = 1'b0;
                  state_d = S_DONE;
               end else begin
                  load = 1'b1;
                  if (filt_q == F_LAST) begin
                     filt_d = '0;
                     if (col_q == RC_LAST) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                     end else begin
                        col_d = col_q + 1'b1;
                     end
                  end else begin
                     filt_d = filt_q + 1'b1;
                  end
               end
            end
         end
         default: ;
      endcase
   end

   // Popcount of the beat being loaded, indexed by the next-state counters.
   always_comb begin
      popcnt_d = '0;
      pidx     = '0;
      widx     = '0;
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            pidx = PW'((int'(row_d) + i) * IMG + int'(col_d) + j);
            widx = WW'(int'(filt_d) * 9 + i * 3 + j);
            if (pixels_flat_i[pidx] == weights_flat_i[widx])
               popcnt_d = popcnt_d + 4'd1;
         end
      end
   end

`ifdef BNN_CONV_POPCNT_OUT_EN
   logic [3:0] popcnt_q;
   always_ff @(posedge clk) begin
      if (!reset_n)  popcnt_q <= '0;
      else if (load) popcnt_q <= popcnt_d;
   end
   assign out_popcnt_o = popcnt_q;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         row_q   <= '0;
         col_q   <= '0;
         filt_q  <= '0;
         valid_q <= 1'b0;
         bit_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         filt_q  <= filt_d;
         valid_q <= valid_d;
         if (load) bit_q <= (popcnt_d >= THR);
      end
   end

   assign out_valid_o = valid_q;
   assign out_bit_o   = bit_q;
   assign out_row_o   = row_q;
   assign out_col_o   = col_q;
   assign out_filt_o  = filt_q;
   assign busy_o      = (state_q == S_RUN);
   assign done_o      = (state_q == S_DONE);

endmodule

// File: tb/tb_bnn_conv3x3.sv
// Scoreboard bench for bnn_conv3x3: reference popcount model fills an expected-beat queue,
// a negedge monitor pops on each handshake and checks hold behaviour under backpressure.
module tb_bnn_conv3x3;

   localparam int IMG = 28;
   localparam int NF  = 8;
   localparam int TH  = 5;
   localparam int OS  = IMG - 2;
   localparam int NBEATS = OS * OS * NF;

   typedef struct packed {
      logic [4:0] row;
      logic [4:0] col;
      logic [2:0] filt;
      logic       b;
      logic [3:0] pc;
   } beat_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic start = 1'b0;
   logic [IMG*IMG-1:0] pixels_flat;
   logic [NF*9-1:0] weights_flat;
   logic out_ready = 1'b1;
   logic out_valid, out_bit, busy, done;
   logic [4:0] out_row, out_col;
   logic [2:0] out_filt;
   logic v4, b4, busy4, done4;
   logic [4:0] r4, c4;
   logic [2:0] f4;
`ifdef BNN_CONV_POPCNT_OUT_EN
   logic [3:0] out_popcnt, pc4;
`endif

   bnn_conv3x3 #(.IMG(IMG), .NFILT(NF), .THRESH(TH)) dut (
      .clk(clk), .reset_n(reset_n), .start_i(start),
      .pixels_flat_i(pixels_flat), .weights_flat_i(weights_flat),
      .out_ready_i(out_ready), .out_valid_o(out_valid), .out_bit_o(out_bit),
      .out_row_o(out_row), .out_col_o(out_col), .out_filt_o(out_filt),
      .busy_o(busy),
`ifdef BNN_CONV_POPCNT_OUT_EN
      .done_o(done), .out_popcnt_o(out_popcnt)
`else
      .done_o(done)
`endif
   );

   bnn_conv3x3 #(.IMG(IMG), .NFILT(NF), .THRESH(4)) dut4 (
      .clk(clk), .reset_n(reset_n), .start_i(start),
      .pixels_flat_i(pixels_flat), .weights_flat_i(weights_flat),
      .out_ready_i(out_ready), .out_valid_o(v4), .out_bit_o(b4),
      .out_row_o(r4), .out_col_o(c4), .out_filt_o(f4),
      .busy_o(busy4),
`ifdef BNN_CONV_POPCNT_OUT_EN
      .done_o(done4), .out_popcnt_o(pc4)
`else
      .done_o(done4)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int acc_cnt = 0;
   int ready_mode = 0;
   beat_t exp_q[$];
   bit pix [IMG][IMG];
   bit w   [NF][3][3];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int ref_pop(input int r, input int c, input int f);
      int n = 0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            if (pix[r+i][c+j] == w[f][i][j]) n++;
      return n;
   endfunction

   task automatic apply_data();
      for (int r = 0; r < IMG; r++)
         for (int c = 0; c < IMG; c++)
            pixels_flat[r*IMG+c] = pix[r][c];
      for (int f = 0; f < NF; f++)
         for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
               weights_flat[f*9+i*3+j] = w[f][i][j];
   endtask

   task automatic build_expected();
      beat_t e;
      int p;
      exp_q.delete();
      for (int r = 0; r < OS; r++)
         for (int c = 0; c < OS; c++)
            for (int f = 0; f < NF; f++) begin
               p = ref_pop(r, c, f);
               e.row = 5'(r); e.col = 5'(c); e.filt = 3'(f);
               e.b = (p >= TH); e.pc = 4'(p);
               exp_q.push_back(e);
            end
   endtask

   // Ready driver
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0: out_ready = 1'b1;
         1: out_ready = ~out_ready;
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // Monitor: handshake at the coming posedge is visible at this negedge
   bit stall_prev = 0;
   beat_t held;
   always @(negedge clk) begin
      beat_t e;
      if (reset_n) begin
         if (stall_prev) begin
            checks++;
            if (!out_valid || out_row != held.row || out_col != held.col ||
                out_filt != held.filt || out_bit != held.b) begin
               errors++;
               $display("FAIL hold actual v%0d r%0d c%0d f%0d b%0d expected v1 r%0d c%0d f%0d b%0d",
                        out_valid, out_row, out_col, out_filt, out_bit, held.row, held.col, held.filt, held.b);
            end
         end
         if (out_valid && out_ready) begin
            acc_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL beat_extra actual r%0d c%0d f%0d expected none", out_row, out_col, out_filt);
            end else begin
               e = exp_q.pop_front();
               if (out_row != e.row || out_col != e.col || out_filt != e.filt || out_bit != e.b) begin
                  errors++;
                  $display("FAIL beat actual r%0d c%0d f%0d b%0d expected r%0d c%0d f%0d b%0d",
                           out_row, out_col, out_filt, out_bit, e.row, e.col, e.filt, e.b);
               end
`ifdef BNN_CONV_POPCNT_OUT_EN
               chk("popcnt", int'(out_popcnt), int'(e.pc));
`endif
            end
         end
         stall_prev = out_valid && !out_ready;
         held.row = out_row; held.col = out_col; held.filt = out_filt; held.b = out_bit;
      end else begin
         stall_prev = 0;
      end
   end

   task automatic do_reset();
      @(posedge clk); #1;
      start = 1'b0;
      reset_n = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
   endtask

   task automatic run_full(input int mode, input bit timing, input bit thr4);
      int n;
      ready_mode = mode;
      build_expected();
      acc_cnt = 0;
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("start_valid", int'(out_valid), 1);
      chk("start_busy", int'(busy), 1);
      if (thr4) begin
         chk("thr5_bit", int'(out_bit), 0);
         chk("thr4_bit", int'(b4), 1);
`ifdef BNN_CONV_POPCNT_OUT_EN
         chk("thr5_pc", int'(out_popcnt), 4);
         chk("thr4_pc", int'(pc4), 4);
`endif
      end
      n = 0;
      while (!done && n < 20000) begin
         @(posedge clk); #1;
         n++;
      end
      if (!done) begin
         errors++;
         $display("FAIL done_timeout actual 0 expected 1");
      end
      if (timing) chk("done_latency", n, NBEATS);
      @(negedge clk);
      chk("accepted", acc_cnt, NBEATS);
      chk("queue_left", exp_q.size(), 0);
      chk("end_valid", int'(out_valid), 0);
      chk("end_busy", int'(busy), 0);
      chk("end_done", int'(done), 1);
      start = 1'b0;
   endtask

   initial begin
      int n;
      pixels_flat = '0;
      weights_flat = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_bit", int'(out_bit), 0);
      chk("rst_rcf", int'({out_row, out_col, out_filt}), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);

      // all ones
      foreach (pix[r, c]) pix[r][c] = 1;
      foreach (w[f, i, j]) w[f][i][j] = 1;
      apply_data();
      do_reset();
      run_full(0, 1, 0);

      // pixels 0, weights 1
      foreach (pix[r, c]) pix[r][c] = 0;
      apply_data();
      do_reset();
      run_full(0, 0, 0);

      // checkerboard image and filter
      foreach (pix[r, c]) pix[r][c] = 1'((r + c) % 2);
      foreach (w[f, i, j]) w[f][i][j] = 1'(((i + j) % 2) == 0);
      apply_data();
      do_reset();
      run_full(0, 0, 0);

      // random data, ready toggling
      foreach (pix[r, c]) pix[r][c] = 1'($urandom_range(0, 1));
      foreach (w[f, i, j]) w[f][i][j] = 1'($urandom_range(0, 1));
      apply_data();
      do_reset();
      run_full(1, 0, 0);

      // reset mid-run after 100 accepted beats
      foreach (pix[r, c]) pix[r][c] = 1'($urandom_range(0, 1));
      apply_data();
      do_reset();
      ready_mode = 2;
      build_expected();
      acc_cnt = 0;
      @(posedge clk); #1;
      start = 1'b1;
      n = 0;
      while (acc_cnt < 100 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      chk("pre_reset_beats", int'(acc_cnt >= 100), 1);
      @(posedge clk); #1;
      reset_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_valid", int'(out_valid), 0);
      chk("midrst_done", int'(done), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_rcf", int'({out_row, out_col, out_filt}), 0);
      ready_mode = 0;
      build_expected();
      acc_cnt = 0;
      #1 reset_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("restart_valid", int'(out_valid), 1);
      chk("restart_rcf", int'({out_row, out_col, out_filt}), 0);
      n = 0;
      while (!done && n < 20000) begin
         @(posedge clk); #1;
         n++;
      end
      @(negedge clk);
      chk("restart_accepted", acc_cnt, NBEATS);
      chk("restart_done", int'(done), 1);
      start = 1'b0;

      // filter 0 with exactly four matching taps at window (0,0)
      foreach (pix[r, c]) pix[r][c] = 1'($urandom_range(0, 1));
      foreach (w[f, i, j]) w[f][i][j] = 1'($urandom_range(0, 1));
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            w[0][i][j] = (i*3 + j < 4) ? pix[i][j] : ~pix[i][j];
      apply_data();
      do_reset();
      run_full(2, 0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
